morse_round_ctrl: RTL

Parametrised Morse game round controller: captures timed key presses into Morse letters, stores player 1's message in an internal letter memory, then replays it against player 2's entry with per-letter scoring and a miss limit. Replaces the gated-clock player/RAM sequencing in the top level with a single-clock, enable-driven FSM. Its status outputs drive the HEX/LED displays and the VGA translator draw strobe.

---
 rtl/morse_round_ctrl_pkg.sv | 19 +
 rtl/morse_round_ctrl_symbol_capture.sv | 95 +++++++++
 rtl/morse_round_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/morse_round_ctrl_pkg.sv
// Shared definitions for the Morse round controller: phase encodings and symbol codes.
package morse_round_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RECORD   = 2'b01,
        ST_PLAYBACK = 2'b10,
        ST_RESULT   = 2'b11
    } state_e;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_DOT   = 2'b01;
    localparam logic [1:0] SYM_DASH  = 2'b11;

    function automatic logic [1:0] sym_of(input int unsigned ticks, input int unsigned dash_ticks);
        return (ticks < dash_ticks) ? SYM_DOT : SYM_DASH;
    endfunction

endpackage

// File: rtl/morse_round_ctrl_symbol_capture.sv
// Key press timing and symbol assembly into the current letter.
// MORSE_TIMEOUT_EN adds an idle auto-commit after TIMEOUT_TICKS released ticks.
module morse_round_ctrl_symbol_capture
    import morse_round_ctrl_pkg::*;
#(
    parameter int SYMS          = 5,
    parameter int DASH_TICKS    = 3,
    parameter int TIMEOUT_TICKS = 4
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    input  logic                active_i,
    input  logic                tick_i,
    input  logic                user_key_i,
    input  logic                clear_i,
    output logic [2*SYMS-1:0]   letter_buf_o,
    output logic                timeout_commit_o
);
    localparam int CW = $clog2(DASH_TICKS + 1);

    logic [CW-1:0]     press_cnt_q, press_cnt_d;
    logic              key_q, key_prev_q;
    logic [2*SYMS-1:0] buf_q, buf_d;
    logic              release_w;

    // The release is acted on one cycle after it is sampled, so the count is
    // held through the first released cycle and cleared on the next.
    assign release_w = !key_prev_q && key_q;

    always_comb begin
        press_cnt_d = press_cnt_q;
        buf_d       = buf_q;
        if (!active_i) begin
            press_cnt_d = '0;
            buf_d       = '0;
        end else begin
            if (user_key_i)
                press_cnt_d = key_q ? '0 : press_cnt_q;
            else if (key_q)
                press_cnt_d = tick_i ? CW'(1) : '0;
            else if (tick_i && press_cnt_q < CW'(DASH_TICKS))
                press_cnt_d = press_cnt_q + 1'b1;

            if (clear_i)
                buf_d = '0;
            else if (release_w && buf_q[2*SYMS-1 -: 2] == SYM_EMPTY)
                buf_d = {buf_q[2*SYMS-3:0], sym_of(32'(press_cnt_q), DASH_TICKS)};
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            press_cnt_q <= '0;
            buf_q       <= '0;
            key_q       <= 1'b1;
            key_prev_q  <= 1'b1;
        end else begin
            press_cnt_q <= press_cnt_d;
            buf_q       <= buf_d;
            key_q       <= user_key_i;
            key_prev_q  <= key_q;
        end
    end

    assign letter_buf_o = buf_q;

`ifdef MORSE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          idle_run_w;

    assign idle_run_w       = active_i && (buf_q != '0) && user_key_i;
    assign timeout_commit_o = idle_run_w && tick_i && (idle_q == TW'(1));

    always_comb begin
        idle_d = idle_q;
        if (!idle_run_w || timeout_commit_o)
            idle_d = TW'(TIMEOUT_TICKS);
        else if (tick_i)
            idle_d = idle_q - 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i)
            idle_q <= TW'(TIMEOUT_TICKS);
        else
            idle_q <= idle_d;
    end
`else
    // TIMEOUT_TICKS only matters when the auto-commit is built.
    assign timeout_commit_o = (TIMEOUT_TICKS < 0);
`endif

endmodule

// File: rtl/morse_round_ctrl.sv
// Morse game round controller: record player 1's letters, replay against player 2.
// Optional idle auto-commit is enabled by defining MORSE_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | waiting for done_pulse to start recording
// ST_RECORD   | player 1 keys letters into memory
// ST_PLAYBACK | player 2 keys letters, each compared to memory
// ST_RESULT   | round over, outputs frozen until done_pulse
module morse_round_ctrl
    import morse_round_ctrl_pkg::*;
#(
    parameter int SYMS          = 5,
    parameter int DEPTH         = 16,
    parameter int DASH_TICKS    = 3,
    parameter int MAX_MISSES    = 3,
    parameter int TIMEOUT_TICKS = 4,
    localparam int AW           = $clog2(DEPTH + 1)
) (
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              tick_i,
    input  logic              user_key_i,
    input  logic              next_pulse_i,
    input  logic              done_pulse_i,
    output logic [1:0]        state_o,
    output logic [2*SYMS-1:0] letter_buf_o,
    output logic [AW-1:0]     wr_count_o,
    output logic [AW-1:0]     rd_addr_o,
    output logic              letter_valid_o,
    output logic              letter_ok_o,
    output logic [3:0]        misses_o,
    output logic              win_o,
    output logic              full_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_count_q, wr_count_d, rd_addr_q, rd_addr_d;
    logic [3:0]        misses_q, misses_d;
    logic              win_q, win_d, ok_q, ok_d, valid_q, valid_d;
    logic              mem_we;
    logic [2*SYMS-1:0] mem_q [DEPTH];
    logic [2*SYMS-1:0] letter_buf;
    logic              timeout_commit, commit, advance, active, full;

    assign active  = (state_q == ST_RECORD) || (state_q == ST_PLAYBACK);
    assign commit  = next_pulse_i || timeout_commit;
    // A commit always wins over a simultaneous phase advance.
    assign advance = done_pulse_i && !commit;
    assign full    = (wr_count_q == AW'(DEPTH));

    morse_round_ctrl_symbol_capture #(
        .SYMS          (SYMS),
        .DASH_TICKS    (DASH_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_capture (
        .clock_i          (clock_i),
        .resetn_i         (resetn_i),
        .active_i         (active),
        .tick_i           (tick_i),
        .user_key_i       (user_key_i),
        .clear_i          (commit),
        .letter_buf_o     (letter_buf),
        .timeout_commit_o (timeout_commit)
    );

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        rd_addr_d  = rd_addr_q;
        misses_d   = misses_q;
        win_d      = win_q;
        ok_d       = ok_q;
        valid_d    = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (advance) state_d = ST_RECORD;
            end
            ST_RECORD: begin
                if (commit) begin
                    if (letter_buf != '0 && !full) begin
                        mem_we     = 1'b1;
                        wr_count_d = wr_count_q + AW'(1);
                    end
                end else if (advance && wr_count_q != '0) begin
                    state_d   = ST_PLAYBACK;
                    rd_addr_d = '0;
                    misses_d  = '0;
                end
            end
            ST_PLAYBACK: begin
                if (commit) begin
                    if (letter_buf != '0) begin
                        valid_d = 1'b1;
                        ok_d    = (letter_buf == mem_q[rd_addr_q[IW-1:0]]);
                        if (ok_d) begin
                            rd_addr_d = rd_addr_q + AW'(1);
                            if (rd_addr_d == wr_count_q) begin
                                state_d = ST_RESULT;
                                win_d   = 1'b1;
                            end
                        end else begin
                            misses_d = misses_q + 4'd1;
                            if (misses_d == 4'(MAX_MISSES)) begin
                                state_d = ST_RESULT;
                                win_d   = 1'b0;
                            end
                        end
                    end
                end else if (advance) begin
                    state_d = ST_RESULT;
                    win_d   = 1'b0;
                end
            end
            ST_RESULT: begin
                if (advance) begin
                    state_d    = ST_IDLE;
                    wr_count_d = '0;
                    rd_addr_d  = '0;
                    misses_d   = '0;
                    win_d      = 1'b0;
                    ok_d       = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q    <= ST_IDLE;
            wr_count_q <= '0;
            rd_addr_q  <= '0;
            misses_q   <= '0;
            win_q      <= 1'b0;
            ok_q       <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            rd_addr_q  <= rd_addr_d;
            misses_q   <= misses_d;
            win_q      <= win_d;
            ok_q       <= ok_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (mem_we) mem_q[wr_count_q[IW-1:0]] <= letter_buf;
    end

    assign state_o        = state_q;
    assign letter_buf_o   = letter_buf;
    assign wr_count_o     = wr_count_q;
    assign rd_addr_o      = rd_addr_q;
    assign letter_valid_o = valid_q;
    assign letter_ok_o    = ok_q;
    assign misses_o       = misses_q;
    assign win_o          = win_q;
    assign full_o         = full;

endmodule
